// File: rtl/alu_ops_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode constants,
// default datapath widths and the sequencing FSM state encoding.
package alu_ops_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    // ALU operation codes (passed through the arbiter unmodified)
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LUI = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_BNE = 4'b0111;
    localparam logic [3:0] OP_BLT = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b1001;

    // One operation in flight: wait for grant, let the ALU settle, hold the response
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way grant logic for the shared ALU.
// Default build: round-robin, the pointer favours the requester that did not win last.
// With ALU_ARB_FIXED_PRIO_EN defined requester 0 always wins a tie and no pointer exists.
module alu_arb_rr2
    import alu_ops_pkg::*;
(
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic rr_ptr_r;

    // Pick at most one winner among valid requesters while enabled
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req_valid == 2'b11) begin
                grant = rr_ptr_r ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end else begin
            grant = 2'b00;
        end
    end

    // After a grant the other requester gets tie priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= 1'b0;
        end else if (grant != 2'b00) begin
            rr_ptr_r <= ~grant[1];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority: requester 0 always beats requester 1
    always_comb begin
        grant = 2'b00;
        if (en) begin
            grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
        end else begin
            grant = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters. Each operation is granted,
// its operands registered toward the ALU, the result captured one cycle later
// and returned on the owner's response channel. One operation in flight.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (see alu_arb_rr2).
module alu_share_arbiter
    import alu_ops_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_zero_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_zero_o,
    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              busy_o
);

    state_e              state_r;
    state_e              state_s;
    logic                owner_r;
    logic [DATA_W-1:0]   rsp_result_r;
    logic                rsp_zero_r;
    logic [1:0]          grant_s;
    logic                arb_en_s;
    logic                accept_s;
    logic                rsp_take_s;

    // Grants only in IDLE; reset masks ready so no handshake is seen during reset
    assign arb_en_s   = (state_r == ST_IDLE) && !reset;
    assign accept_s   = (grant_s != 2'b00);
    assign rsp_take_s = owner_r ? rsp1_ready_i : rsp0_ready_i;

    alu_arb_rr2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .en        (arb_en_s),
        .req_valid ({req1_valid_i, req0_valid_i}),
        .grant     (grant_s)
    );

    assign req0_ready_o  = grant_s[0];
    assign req1_ready_o  = grant_s[1];

    assign busy_o        = (state_r != ST_IDLE);
    assign rsp0_valid_o  = (state_r == ST_RESP) && (owner_r == 1'b0);
    assign rsp1_valid_o  = (state_r == ST_RESP) && (owner_r == 1'b1);
    assign rsp0_result_o = rsp_result_r;
    assign rsp1_result_o = rsp_result_r;
    assign rsp0_zero_o   = rsp_zero_r;
    assign rsp1_zero_o   = rsp_zero_r;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: accept -> one settle cycle -> hold response until taken
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_EXEC;
                else          state_s = ST_IDLE;
            end
            ST_EXEC: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_s) state_s = ST_IDLE;
                else            state_s = ST_RESP;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand/owner latch on accept; result capture at the end of EXEC.
    // ALU inputs only change on accept so the ALU does not toggle when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_r      <= 1'b0;
            alu_op_o     <= OP_W'(OP_ADD);
            alu_a_o      <= {DATA_W{1'b0}};
            alu_b_o      <= {DATA_W{1'b0}};
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_zero_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                owner_r  <= grant_s[1];
                alu_op_o <= grant_s[1] ? req1_op_i : req0_op_i;
                alu_a_o  <= grant_s[1] ? req1_a_i  : req0_a_i;
                alu_b_o  <= grant_s[1] ? req1_b_i  : req0_b_i;
            end
            if (state_r == ST_EXEC) begin
                rsp_result_r <= alu_result_i;
                rsp_zero_r   <= alu_zero_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and model-checked bench for alu_share_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_zero;
    wire  [31:0] rsp_res0;
    wire  [31:0] rsp_res1;
    wire  [3:0]  alu_op;
    wire  [31:0] alu_a;
    wire  [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    wire         busy;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]), .req0_op_i(req_op[0]),
        .req0_a_i(req_a[0]), .req0_b_i(req_b[0]),
        .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]), .req1_op_i(req_op[1]),
        .req1_a_i(req_a[1]), .req1_b_i(req_b[1]),
        .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]),
        .rsp0_result_o(rsp_res0), .rsp0_zero_o(rsp_zero[0]),
        .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]),
        .rsp1_result_o(rsp_res1), .rsp1_zero_o(rsp_zero[1]),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero), .busy_o(busy)
    );

    // Behavioural ALU. Branch compares return 0 (zero=1) when the branch is taken.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = b << 12;
            4'd2:    alu_f = a | b;
            4'd3:    alu_f = a << b[4:0];
            4'd4:    alu_f = a - b;
            4'd5:    alu_f = a >> b[4:0];
            4'd6:    alu_f = a ^ b;
            4'd7:    alu_f = (a != b) ? 32'd0 : 32'd1;
            4'd8:    alu_f = ($signed(a) < $signed(b)) ? 32'd0 : 32'd1;
            4'd9:    alu_f = a & b;
            default: alu_f = 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_res == 32'd0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int p = 0; p < 2; p++) begin
            req_op[p] = 4'd0;
            req_a[p]  = 32'd0;
            req_b[p]  = 32'd0;
        end
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Full single transaction with response ready high; checks timing and data inline
    task automatic run_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_zero);
        logic [1:0]  sel;
        logic [31:0] got;
        sel = (id == 0) ? 2'b01 : 2'b10;
        req_op[id] = op; req_a[id] = a; req_b[id] = b;
        req_valid = sel; rsp_ready = 2'b11;
        settle();
        total++; if (req_ready !== sel) begin bad++; $display("FAIL op_ready got=%b exp=%b", req_ready, sel); end
        tick();
        req_valid = 2'b00;
        settle();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL op_exec_rsp got=%b exp=00", rsp_valid); end
        tick();
        settle();
        got = (id == 0) ? rsp_res0 : rsp_res1;
        total++; if (rsp_valid !== sel) begin bad++; $display("FAIL op_rsp_valid got=%b exp=%b", rsp_valid, sel); end
        total++; if (got !== exp_res) begin bad++; $display("FAIL op_result got=%h exp=%h", got, exp_res); end
        total++; if (rsp_zero[id] !== exp_zero) begin bad++; $display("FAIL op_zero got=%b exp=%b", rsp_zero[id], exp_zero); end
        tick();
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL op_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        req_valid = 2'b11;
        tick();
        settle();
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin bad++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
        total++; if ({rsp_res0, rsp_res1, rsp_zero} !== 66'd0) begin bad++; $display("FAIL rst_rsp got=%h/%h/%b exp=0", rsp_res0, rsp_res1, rsp_zero); end
        req_valid = 2'b00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        req_op[0] = 4'd0; req_a[0] = 32'd5; req_b[0] = 32'd7;
        req_valid = 2'b01; rsp_ready = 2'b11;
        settle();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        settle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", busy); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL t1_rsp_early got=%b exp=00", rsp_valid); end
        total++; if ({alu_op, alu_a, alu_b} !== {4'd0, 32'd5, 32'd7}) begin bad++; $display("FAIL t1_alu_in got=%h/%h/%h exp=0/5/7", alu_op, alu_a, alu_b); end
        tick();
        settle();
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL t1_rsp_valid got=%b exp=01", rsp_valid); end
        total++; if (rsp_res0 !== 32'd12) begin bad++; $display("FAIL t1_result got=%0d exp=12", rsp_res0); end
        total++; if (rsp_zero[0] !== 1'b0) begin bad++; $display("FAIL t1_zero got=%b exp=0", rsp_zero[0]); end
        tick();
        settle();
        total++; if ({busy, rsp_valid} !== 3'b000) begin bad++; $display("FAIL t1_done got=%b exp=000", {busy, rsp_valid}); end
    endtask

    task automatic test_round_robin;
        int g [4];
        int exp_g [4];
        int n;
        n = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        apply_reset();
        req_op[0] = 4'd0; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = 4'd2; req_a[1] = 32'd2; req_b[1] = 32'd4;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            settle();
            total++; if (req_ready == 2'b11) begin bad++; $display("FAIL t2_onehot cycle=%0d got=%b exp=not 11", c, req_ready); end
            if (req_ready != 2'b00 && n < 4) begin
                g[n] = req_ready[1] ? 1 : 0;
                n++;
            end
            tick();
        end
        req_valid = 2'b00;
        total++; if (n !== 4) begin bad++; $display("FAIL t2_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            total++; if (k < n && g[k] !== exp_g[k]) begin bad++; $display("FAIL t2_grant idx=%0d got=%0d exp=%0d", k, g[k], exp_g[k]); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_hold;
        idle_inputs();
        req_op[1] = 4'd4; req_a[1] = 32'd9; req_b[1] = 32'd9;
        req_valid = 2'b10; rsp_ready = 2'b01;
        settle();
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL t3_ready1 got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b01; req_op[0] = 4'd0; req_a[0] = 32'd3; req_b[0] = 32'd4;
        settle();
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL t3_exec_ready got=%b exp=00", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL t3_hold_valid k=%0d got=%b exp=10", k, rsp_valid); end
            total++; if ({rsp_res1, rsp_zero[1]} !== {32'd0, 1'b1}) begin bad++; $display("FAIL t3_hold_data k=%0d got=%h/%b exp=0/1", k, rsp_res1, rsp_zero[1]); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL t3_hold_ready k=%0d got=%b exp=00", k, req_ready); end
            tick();
        end
        rsp_ready = 2'b11;
        settle();
        total++; if ({rsp_valid, req_ready} !== 4'b1000) begin bad++; $display("FAIL t3_handshake got=%b exp=1000", {rsp_valid, req_ready}); end
        tick();
        settle();
        total++; if ({rsp_valid, req_ready} !== 4'b0001) begin bad++; $display("FAIL t3_regrant got=%b exp=0001", {rsp_valid, req_ready}); end
        tick();
        req_valid = 2'b00;
        tick();
        settle();
        total++; if (rsp_valid !== 2'b01 || rsp_res0 !== 32'd7) begin bad++; $display("FAIL t3_req0_rsp got=%b/%0d exp=01/7", rsp_valid, rsp_res0); end
        tick();
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        req_op[0] = 4'd0; req_a[0] = 32'd5; req_b[0] = 32'd6;
        req_valid = 2'b01; rsp_ready = 2'b11;
        settle();
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t4_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b10;
        reset = 1'b1;
        settle();
        total++; if ({busy, rsp_valid, req_ready} !== 5'b00000) begin bad++; $display("FAIL t4_rst_ctrl got=%b exp=00000", {busy, rsp_valid, req_ready}); end
        total++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin bad++; $display("FAIL t4_rst_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
        tick();
        reset = 1'b0;
        req_valid = 2'b00;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_busy got=%b exp=0", busy); end
        tick();
        settle();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL t4_op_lost got=%b exp=00", rsp_valid); end
        run_op(0, 4'd3, 32'd1, 32'd4, 32'd16, 1'b0);
    endtask

    task automatic test_lui_blt;
        run_op(0, 4'd1, 32'd0, 32'h00000001, 32'h00001000, 1'b0);
        run_op(1, 4'd8, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1);
    endtask

    task automatic test_random;
        int       m_state;
        int       m_owner;
        int       m_ptr;
        int       w;
        int       clr;
        int       done;
        logic [31:0] m_res;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        logic [31:0] got;
        m_state = 0; m_owner = 0; m_ptr = 0; m_res = 32'd0; done = 0;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
                    req_valid[p] = 1'b1;
                    req_op[p] = 4'($urandom_range(0, 15));
                    req_a[p] = $urandom;
                    req_b[p] = $urandom;
                    if ($urandom_range(0, 3) == 0) req_b[p] = req_a[p];
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            settle();
            w = -1;
            exp_rdy = 2'b00;
            if (m_state == 0) begin
                if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = m_ptr;
`endif
                end else if (req_valid[0]) begin
                    w = 0;
                end else if (req_valid[1]) begin
                    w = 1;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL t6_ready cycle=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            exp_rv = (m_state == 2) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL t6_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
            if (m_state == 2) begin
                got = (m_owner == 1) ? rsp_res1 : rsp_res0;
                total++; if (got !== m_res || rsp_zero[m_owner] !== (m_res == 32'd0)) begin bad++; $display("FAIL t6_result cycle=%0d got=%h/%b exp=%h/%b", c, got, rsp_zero[m_owner], m_res, (m_res == 32'd0)); end
            end
            clr = -1;
            case (m_state)
                0: if (w >= 0) begin
                    m_owner = w;
                    m_res = alu_f(req_op[w], req_a[w], req_b[w]);
                    m_ptr = (w == 0) ? 1 : 0;
                    m_state = 1;
                    clr = w;
                end
                1: m_state = 2;
                default: if (rsp_ready[m_owner]) begin m_state = 0; done++; end
            endcase
            tick();
            if (clr >= 0) req_valid[clr] = 1'b0;
        end
        total++; if (done <= 20) begin bad++; $display("FAIL t6_progress got=%0d exp=>20", done); end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_lui_blt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
